// File: rtl/cmp_threshold_monitor_if.sv
// Sample/flag bundle between a comparator-side driver and cmp_threshold_monitor.
// The master drives the comparator flags and the acknowledge; the slave (the monitor) drives the alarm outputs.
interface cmp_threshold_monitor_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             agb;
  logic             asb;
  logic             aeb;
  logic             alarm_ack;
  logic             alarm;
  logic             alarm_rise;
  logic             alarm_fall;
  logic             flag_err;
  logic [CNT_W-1:0] run_cnt;

  modport master (
    output in_valid, agb, asb, aeb, alarm_ack,
    input  alarm, alarm_rise, alarm_fall, flag_err, run_cnt
  );

  modport slave (
    input  in_valid, agb, asb, aeb, alarm_ack,
    output alarm, alarm_rise, alarm_fall, flag_err, run_cnt
  );
endinterface

// File: rtl/cmp_threshold_monitor.sv
// Persistence/hysteresis filter on the a-vs-b comparator flags, producing a clean alarm level and edge pulses.
// Optional build macro ALARM_STICKY_EN: the alarm latches until alarm_ack instead of clearing on asb runs.
module cmp_threshold_monitor #(
  parameter int PERSIST_CNT = 3,
  parameter int CLEAR_CNT   = 4,
  parameter int CNT_W       = 4
) (
  input logic                    clk,
  input logic                    rst,
  cmp_threshold_monitor_if.slave mon
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PEND_HI  = 2'd1;
  localparam logic [1:0] ST_ALARM    = 2'd2;
  localparam logic [1:0] ST_PEND_CLR = 2'd3;

  localparam logic [CNT_W-1:0] PERSIST_T = CNT_W'(PERSIST_CNT);
  localparam logic [CNT_W-1:0] CLEAR_T   = CNT_W'(CLEAR_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             alarm_q, rise_q, fall_q, err_q;
  logic             alarm_nxt, err_nxt;
  logic [2:0]       flags;
  logic             onehot;
  logic             ack_take;

  assign flags   = {mon.agb, mon.asb, mon.aeb};
  assign onehot  = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign cnt_inc = cnt + CNT_ONE;

`ifdef ALARM_STICKY_EN
  // An acknowledge in ALARM wins over whatever sample arrives in that cycle.
  assign ack_take = mon.alarm_ack && (state == ST_ALARM);
`else
  logic unused_ack;
  assign unused_ack = mon.alarm_ack;
  assign ack_take   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    if (ack_take) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = CNT_ZERO;
    end else if (mon.in_valid) begin
      if (!onehot) begin
        // Corrupt flag sets are reported and dropped without touching the filter.
        err_nxt = 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (mon.agb) begin
              if (PERSIST_T == CNT_ONE) begin
                state_nxt = ST_ALARM;
                cnt_nxt   = CNT_ZERO;
              end else begin
                state_nxt = ST_PEND_HI;
                cnt_nxt   = CNT_ONE;
              end
            end else begin
              cnt_nxt = CNT_ZERO;
            end
          end
          ST_PEND_HI: begin
            if (mon.agb) begin
              if (cnt_inc == PERSIST_T) begin
                state_nxt = ST_ALARM;
                cnt_nxt   = CNT_ZERO;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else begin
              state_nxt = ST_IDLE;
              cnt_nxt   = CNT_ZERO;
            end
          end
          ST_ALARM: begin
`ifndef ALARM_STICKY_EN
            if (mon.asb) begin
              if (CLEAR_T == CNT_ONE) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
              end else begin
                state_nxt = ST_PEND_CLR;
                cnt_nxt   = CNT_ONE;
              end
            end
`endif
          end
          ST_PEND_CLR: begin
            // Equality sits inside the hysteresis band, so it neither counts nor aborts the clear run.
            if (mon.asb) begin
              if (cnt_inc == CLEAR_T) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else if (mon.agb) begin
              state_nxt = ST_ALARM;
              cnt_nxt   = CNT_ZERO;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign alarm_nxt = (state_nxt == ST_ALARM) || (state_nxt == ST_PEND_CLR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= CNT_ZERO;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      alarm_q <= alarm_nxt;
      rise_q  <= alarm_nxt & ~alarm_q;
      fall_q  <= ~alarm_nxt & alarm_q;
      err_q   <= err_nxt;
    end
  end

  assign mon.alarm      = alarm_q;
  assign mon.alarm_rise = rise_q;
  assign mon.alarm_fall = fall_q;
  assign mon.flag_err   = err_q;
  assign mon.run_cnt    = cnt;

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Directed scoreboard bench for cmp_threshold_monitor with default parameters (PERSIST 3, CLEAR 4).
// Expected outputs are queued as each sample is driven and popped once the registered result is visible.
module tb_cmp_threshold_monitor;

  localparam logic [2:0] AGB = 3'b100;
  localparam logic [2:0] ASB = 3'b010;
  localparam logic [2:0] AEB = 3'b001;

  typedef struct packed {
    logic       alarm;
    logic       rise;
    logic       fall;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  exp_t  exp_q[$];
  string tag_q[$];

  cmp_threshold_monitor_if #(.CNT_W(4)) mon_if ();

  cmp_threshold_monitor #(
    .PERSIST_CNT(3),
    .CLEAR_CNT  (4),
    .CNT_W      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput();
    exp_t  e;
    string t;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=nonzero entries");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (mon_if.alarm === e.alarm) else begin
        failures++;
        $error("[TB] FAIL %s alarm observed=%b expected=%b", t, mon_if.alarm, e.alarm);
      end
      checks++;
      assert (mon_if.alarm_rise === e.rise) else begin
        failures++;
        $error("[TB] FAIL %s alarm_rise observed=%b expected=%b", t, mon_if.alarm_rise, e.rise);
      end
      checks++;
      assert (mon_if.alarm_fall === e.fall) else begin
        failures++;
        $error("[TB] FAIL %s alarm_fall observed=%b expected=%b", t, mon_if.alarm_fall, e.fall);
      end
      checks++;
      assert (mon_if.flag_err === e.err) else begin
        failures++;
        $error("[TB] FAIL %s flag_err observed=%b expected=%b", t, mon_if.flag_err, e.err);
      end
      checks++;
      assert (mon_if.run_cnt === e.cnt) else begin
        failures++;
        $error("[TB] FAIL %s run_cnt observed=%0d expected=%0d", t, mon_if.run_cnt, e.cnt);
      end
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the edge, then check.
  task automatic applyStimulus(input logic v, input logic [2:0] f, input logic ack,
                               input logic ea, input logic er, input logic ef,
                               input logic ee, input logic [3:0] ec, input string tag);
    exp_t e;
    @(negedge clk);
    mon_if.in_valid  = v;
    {mon_if.agb, mon_if.asb, mon_if.aeb} = f;
    mon_if.alarm_ack = ack;
    e.alarm = ea;
    e.rise  = er;
    e.fall  = ef;
    e.err   = ee;
    e.cnt   = ec;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1;
    mon_if.in_valid  = 1'b0;
    mon_if.agb       = 1'b0;
    mon_if.asb       = 1'b0;
    mon_if.aeb       = 1'b0;
    mon_if.alarm_ack = 1'b0;

    // Reset with random flags
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'b0, 0, 0, 0, 0, 4'd0, "reset");
    rst = 1'b0;

    // Three consecutive agb raise the alarm
    applyStimulus(1'b1, AGB, 1'b0, 0, 0, 0, 0, 4'd1, "persist_1");
    applyStimulus(1'b1, AGB, 1'b0, 0, 0, 0, 0, 4'd2, "persist_2");
    applyStimulus(1'b1, AGB, 1'b0, 1, 1, 0, 0, 4'd0, "persist_3_rise");
    applyStimulus(1'b1, AEB, 1'b0, 1, 0, 0, 0, 4'd0, "alarm_aeb_stay");

`ifdef ALARM_STICKY_EN
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, ASB, 1'b0, 1, 0, 0, 0, 4'd0, "sticky_asb");
    applyStimulus(1'b1, AGB, 1'b1, 0, 0, 1, 0, 4'd0, "sticky_ack_fall");
    applyStimulus(1'b0, AGB, 1'b1, 0, 0, 0, 0, 4'd0, "sticky_ack_idle");
`else
    applyStimulus(1'b1, ASB, 1'b1, 1, 0, 0, 0, 4'd1, "clr_1_ack_ignored");
    applyStimulus(1'b1, ASB, 1'b0, 1, 0, 0, 0, 4'd2, "clr_2");
    applyStimulus(1'b1, AEB, 1'b0, 1, 0, 0, 0, 4'd2, "clr_aeb_hold");
    applyStimulus(1'b1, ASB, 1'b0, 1, 0, 0, 0, 4'd3, "clr_3");
    applyStimulus(1'b1, AGB, 1'b0, 1, 0, 0, 0, 4'd0, "clr_abort_agb");
    applyStimulus(1'b1, ASB, 1'b0, 1, 0, 0, 0, 4'd1, "clr4_1");
    applyStimulus(1'b1, ASB, 1'b0, 1, 0, 0, 0, 4'd2, "clr4_2");
    applyStimulus(1'b1, ASB, 1'b0, 1, 0, 0, 0, 4'd3, "clr4_3");
    applyStimulus(1'b1, ASB, 1'b0, 0, 0, 1, 0, 4'd0, "clr4_4_fall");
    applyStimulus(1'b0, AGB, 1'b1, 0, 0, 0, 0, 4'd0, "idle_ack_ignored");
`endif

    // Non-consecutive run restarts
    applyStimulus(1'b1, AGB, 1'b0, 0, 0, 0, 0, 4'd1, "run_1");
    applyStimulus(1'b1, AGB, 1'b0, 0, 0, 0, 0, 4'd2, "run_2");
    applyStimulus(1'b1, AEB, 1'b0, 0, 0, 0, 0, 4'd0, "run_aeb_restart");
    applyStimulus(1'b1, AGB, 1'b0, 0, 0, 0, 0, 4'd1, "run_4");
    applyStimulus(1'b1, AGB, 1'b0, 0, 0, 0, 0, 4'd2, "run_5");
    applyStimulus(1'b1, AGB, 1'b0, 1, 1, 0, 0, 4'd0, "run_6_rise");

`ifdef ALARM_STICKY_EN
    applyStimulus(1'b1, ASB, 1'b1, 0, 0, 1, 0, 4'd0, "back_idle_ack");
`else
    applyStimulus(1'b1, ASB, 1'b0, 1, 0, 0, 0, 4'd1, "back_1");
    applyStimulus(1'b1, ASB, 1'b0, 1, 0, 0, 0, 4'd2, "back_2");
    applyStimulus(1'b1, ASB, 1'b0, 1, 0, 0, 0, 4'd3, "back_3");
    applyStimulus(1'b1, ASB, 1'b0, 0, 0, 1, 0, 4'd0, "back_4_fall");
`endif

    // Integrity errors and invalid gaps inside PEND_HI
    applyStimulus(1'b1, AGB,    1'b0, 0, 0, 0, 0, 4'd1, "err_pre_1");
    applyStimulus(1'b1, AGB,    1'b0, 0, 0, 0, 0, 4'd2, "err_pre_2");
    applyStimulus(1'b1, 3'b110, 1'b0, 0, 0, 0, 1, 4'd2, "err_110");
    applyStimulus(1'b0, 3'b110, 1'b0, 0, 0, 0, 0, 4'd2, "gap_after_110");
    applyStimulus(1'b1, 3'b000, 1'b0, 0, 0, 0, 1, 4'd2, "err_000");
    applyStimulus(1'b0, ASB,    1'b0, 0, 0, 0, 0, 4'd2, "gap_asb_hold");
    applyStimulus(1'b1, AGB,    1'b0, 1, 1, 0, 0, 4'd0, "err_resume_rise");

    // Reset in ALARM gives no fall pulse
    rst = 1'b1;
    applyStimulus(1'b1, AGB, 1'b0, 0, 0, 0, 0, 4'd0, "reset_in_alarm");
    rst = 1'b0;
    applyStimulus(1'b1, AGB, 1'b0, 0, 0, 0, 0, 4'd1, "post_reset_agb");
    rst = 1'b1;
    applyStimulus(1'b1, AGB, 1'b0, 0, 0, 0, 0, 4'd0, "reset_in_pend");
    rst = 1'b0;
    applyStimulus(1'b1, ASB, 1'b0, 0, 0, 0, 0, 4'd0, "idle_asb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
